// File: rtl/seg_display_scanner.sv
// ----------------------------------------------------------------------------
// seg_display_scanner
//
// Time-multiplexes a 4-digit common-anode seven-segment display for the
// one-second countdown stage. In RUN the BCD seconds pair is shown on the two
// right-hand digits (tens on digit 1, units on digit 0) and the left two
// digits are blank. While the countdown fail flag is high the block sits in
// ALARM and shows a blinking "FAIL" across all four digits.
//
// The seconds pair is captured once per frame, at the end of the last digit,
// so a single frame always shows one coherent value.
//
// Parameters:
//   CLK_HZ      input clock frequency
//   REFRESH_HZ  digit-advance rate (CLK_HZ/REFRESH_HZ cycles per digit)
//   BLINK_HZ    alarm blink rate (CLK_HZ/(2*BLINK_HZ) cycles per half-period)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   secondsLEFT   BCD tens digit
//   secondsRIGHT  BCD units digit
//   fail          countdown-expired flag, level, synchronous to clk
//   an[3:0]       digit anodes, active-low one-hot, an[0] = rightmost digit
//   seg[6:0]      cathodes {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low, held off (1)
//   alarm         high while the FSM is in ALARM
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a zero tens digit is blanked in RUN
//                          unless the units digit is also zero ("00").
// ----------------------------------------------------------------------------
module seg_display_scanner #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] secondsLEFT,
    input  logic [3:0] secondsRIGHT,
    input  logic       fail,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       alarm
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int DIGIT_TICKS = CLK_HZ / REFRESH_HZ;
    localparam int BLINK_TICKS = CLK_HZ / (2 * BLINK_HZ);
    localparam int DW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    // ------------------------------------------------------------------------
    // Segment patterns, {g,f,e,d,c,b,a}, active-low
    // ------------------------------------------------------------------------
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ALARM = 1'b1
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;   // non-BCD input
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   dwell_cnt_q;
    logic [1:0]      idx_q;
    logic [BW-1:0]   blink_cnt_q;
    logic            blink_on_q;
    logic [3:0]      snap_l_q;
    logic [3:0]      snap_r_q;
    logic [3:0]      an_d;
    logic [6:0]      seg_d;
    logic            tick;

    assign tick = (dwell_cnt_q == DWELL_LAST);

    // ------------------------------------------------------------------------
    // Dwell counter and digit index
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt_q <= '0;
            idx_q       <= 2'd0;
        end else if (tick) begin
            dwell_cnt_q <= '0;
            idx_q       <= idx_q + 2'd1;   // 3 wraps to 0 naturally
        end else begin
            dwell_cnt_q <= dwell_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame snapshot: loaded as the last digit of a frame finishes, so the
    // next frame starts with a fresh, coherent value. Runs in ALARM too, so
    // RUN resumes with current time.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_l_q <= 4'd0;
            snap_r_q <= 4'd0;
        end else if (tick && (idx_q == 2'd3)) begin
            snap_l_q <= secondsLEFT;
            snap_r_q <= secondsRIGHT;
        end
    end

    // ------------------------------------------------------------------------
    // Run/alarm FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in a combinational block is given a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        alarm   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fail) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                alarm = 1'b1;
                if (!fail) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------------
    // Blink generator: held cleared (phase on) outside ALARM, so every alarm
    // episode begins with the message visible for a full half-period.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (state_q != ST_ALARM) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Digit content for the current index
    // ------------------------------------------------------------------------
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = SEG_BLANK;
        if (state_q == ST_ALARM) begin
            case (idx_q)
                2'd3:    seg_d = SEG_F;
                2'd2:    seg_d = SEG_A;
                2'd1:    seg_d = SEG_I;
                default: seg_d = SEG_L;
            endcase
            // Off phase darkens the display; the index keeps scanning.
            if (!blink_on_q) begin
                an_d = 4'b1111;
            end
        end else begin
            case (idx_q)
                2'd0: seg_d = bcd_to_seg(snap_r_q);
                2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                    if ((snap_l_q == 4'd0) && (snap_r_q != 4'd0)) begin
                        seg_d = SEG_BLANK;
                    end else begin
                        seg_d = bcd_to_seg(snap_l_q);
                    end
`else
                    seg_d = bcd_to_seg(snap_l_q);
`endif
                end
                default: seg_d = SEG_BLANK;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered display outputs: glitch-free drive to the pins, one cycle
    // behind the index/state registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

    assign dp = 1'b1;

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Downstream consumer of the one-second countdown stage: takes its BCD seconds pair (LEFT = tens, RIGHT = units) and its fail flag.
- Drives a 4-digit common-anode seven-segment display by time-multiplexing.
- In normal run, shows the two-digit countdown on the right-hand digits.
- On fail, shows a blinking "FAIL" message until fail drops.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- REFRESH_HZ, 1000, digit-advance rate; DIGIT_TICKS = CLK_HZ/REFRESH_HZ clock cycles per digit dwell.
- BLINK_HZ, 2, alarm blink rate; BLINK_TICKS = CLK_HZ/(2*BLINK_HZ) cycles per on/off half-period.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- secondsLEFT  input  4  BCD tens digit from the countdown stage.
- secondsRIGHT  input  4  BCD units digit from the countdown stage.
- fail  input  1  countdown-expired flag, level, synchronous to clk.
- an  output  4  digit anodes, active-low, one-hot; an[0] is the rightmost digit.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; always 1.
- alarm  output  1  high while FSM is in ALARM.

Behaviour:
- Reset (reset=0, async) values:
  - an=4'b1111, seg=7'b1111111, dp=1, alarm=0.
  - digit index idx=0, dwell counter=0, blink counter=0, blink phase=on.
  - snapshot regs snapL=snapR=0; FSM=RUN.
- Dwell counter counts 0..DIGIT_TICKS-1. A tick is generated at terminal count, then the counter wraps to 0. Each tick advances idx by 1 mod 4 (3 wraps to 0).
- Snapshot: on a tick with idx==3, snapL<=secondsLEFT and snapR<=secondsRIGHT. One frame always shows one coherent value, with no tearing.
- Outputs are registered: an/seg reflect the new idx one cycle after the tick. Otherwise an = ~(4'b0001<<idx).
- Digit content in RUN:
  - idx0 = decode(snapR), idx1 = decode(snapL), idx2/idx3 = blank.
- Decode table:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any value >9 = dash 0111111; blank = 1111111.
- Digit content in ALARM:
  - idx3 = F 0001110, idx2 = A 0001000, idx1 = I 1111001, idx0 = L 1000111.
  - When blink phase is off, an=4'b1111; idx keeps scanning.
- FSM:
  - RUN -> ALARM when fail==1 on any clock edge, not tied to a tick. On entry, blink counter=0 and phase=on. alarm goes high the cycle after fail is sampled.
  - ALARM -> RUN when fail==0 on any clock edge. Display reverts at the next registered update, using the current snapshot.
  - Blink counter runs only in ALARM. Phase toggles at BLINK_TICKS-1, then the counter wraps.
- Simultaneous events:
  - fail rise coinciding with a tick: the state change and idx advance both take effect, and that digit shows ALARM content.
  - A snapshot tick during ALARM still loads snapshots.
- reset mid-frame or mid-blink: all state returns to reset values immediately. Scanning resumes at idx0 after release.
- fail held high across reset release: enters ALARM on the first edge after release.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: in RUN, idx1 shows blank when snapL==0 (e.g. "5" rather than "05"). It shows "0" only when snapR is also 0, so "00" is displayed. Dash handling is unchanged; ALARM is unaffected.
- Undefined: idx1 always shows decode(snapL).

Test Plan:
- Bench parameters: CLK_HZ=16, REFRESH_HZ=4 (DIGIT_TICKS=4), BLINK_HZ=1 (BLINK_TICKS=8).
1. Reset hold, then release with LEFT=4, RIGHT=2, fail=0 -> an/seg=1111/1111111 during reset. After the first frame: an=1110 with seg=0011001? No: an=1110 with seg=0100100 ("2"), an=1101 with seg=0011001 ("4"), an=1011 and an=0111 with seg blank. Each digit dwells 4 cycles.
2. Change RIGHT 2->1 while idx=1 -> frame keeps showing "2" until the idx==3 tick; the next frame shows "1".
3. Assert fail=1 -> alarm=1 next cycle. Digits show L/I/A/F; an=1111 for 8 cycles out of every 16; blink starts in the on phase.
4. Drop fail to 0 in ALARM -> alarm=0 next cycle, blink stops, time digits return.
5. Drive LEFT=4'hC -> idx1 shows dash 0111111. Then pulse reset low mid-dwell -> immediate an=1111, idx restarts at 0 after release.
6. LEADING_ZERO_BLANK_EN defined, LEFT=0 RIGHT=7 -> idx1 blank, idx0 1111000. LEFT=0 RIGHT=0 -> idx1 1000000.
